// File: rtl/eai_wb_pkg.sv
// Shared definitions for the EAI write-back drain: payload layout,
// output-register state encoding and default sizing values.
package eai_wb_pkg;

    // Default sizing: ping-pong depth and watchdog threshold.
    localparam int OUTS_MAX_DEF    = 2;
    localparam int STALL_LIMIT_DEF = 255;

    // Payload is {rdidx, wdat}: write data sits at bit 0 and the register
    // index starts immediately above the data field.
    localparam int PAYLOAD_WDAT_LSB = 0;

    function automatic int payload_rdidx_lsb(input int dw);
        return dw;
    endfunction

    // Output register occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } wb_state_e;

endpackage

// File: rtl/eai_wb_outreg.sv
// Single-entry output register between the result buffer and the
// register-file write port. One entry per cycle when the write port keeps up;
// the held entry stays stable while the write port stalls.
import eai_wb_pkg::*;

module eai_wb_outreg #(
    parameter int DW      = 32,
    parameter int RFIDX_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW+RFIDX_W-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out_wdat,
    output logic [RFIDX_W-1:0]    out_rdidx
);

    localparam int RDIDX_LSB = payload_rdidx_lsb(DW);

    wb_state_e          state_reg;
    logic [DW-1:0]      wdat_reg;
    logic [RFIDX_W-1:0] rdidx_reg;
    logic               in_hs;

    // Accept a new entry when empty or when the held one leaves this cycle.
    assign in_ready  = (state_reg == ST_EMPTY) | out_ready;
    assign in_hs     = in_valid & in_ready;
    assign out_valid = (state_reg == ST_HOLD);
    assign out_wdat  = wdat_reg;
    assign out_rdidx = rdidx_reg;

    // EMPTY/HOLD state machine; loading a new entry always lands in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_EMPTY;
            wdat_reg  <= '0;
            rdidx_reg <= '0;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_hs) begin
                        state_reg <= ST_HOLD;
                        wdat_reg  <= in_data[PAYLOAD_WDAT_LSB +: DW];
                        rdidx_reg <= in_data[RDIDX_LSB +: RFIDX_W];
                    end
                end
                ST_HOLD: begin
                    if (in_hs) begin
                        wdat_reg  <= in_data[PAYLOAD_WDAT_LSB +: DW];
                        rdidx_reg <= in_data[RDIDX_LSB +: RFIDX_W];
                    end else if (out_ready) begin
                        state_reg <= ST_EMPTY;
                    end
                end
                default: state_reg <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/eai_wb_drain.sv
// EAI write-back drain: moves completed EAI results from the ping-pong
// buffer into the register-file write port, tracks outstanding dispatches
// as issue credits, and optionally watches for a stuck write port.
// Optional feature: define EAI_WB_STALL_WDOG_EN to build the stall watchdog;
// without it stall_err is constant 0.
import eai_wb_pkg::*;

module eai_wb_drain #(
    parameter int DW          = 32,
    parameter int RFIDX_W     = 5,
    parameter int OUTS_MAX    = OUTS_MAX_DEF,
    parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic                  buf_valid,
    output logic                  buf_ready,
    input  logic [DW+RFIDX_W-1:0] buf_data,
    output logic                  wbck_valid,
    input  logic                  wbck_ready,
    output logic [DW-1:0]         wbck_wdat,
    output logic [RFIDX_W-1:0]    wbck_rdidx,
    output logic                  busy,
    output logic                  stall_err
);

    localparam int CNT_W = $clog2(OUTS_MAX + 1);

    // Reject nonsensical sizing at elaboration.
    if (OUTS_MAX < 1 || STALL_LIMIT < 1) begin : g_param_check
        $error("eai_wb_drain: OUTS_MAX and STALL_LIMIT must be at least 1");
    end

    logic [CNT_W-1:0] cnt_reg;
    logic             issue_hs;
    logic             wb_hs;
    logic             cnt_zero;

    eai_wb_outreg #(
        .DW      (DW),
        .RFIDX_W (RFIDX_W)
    ) u_outreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (buf_valid),
        .in_ready  (buf_ready),
        .in_data   (buf_data),
        .out_valid (wbck_valid),
        .out_ready (wbck_ready),
        .out_wdat  (wbck_wdat),
        .out_rdidx (wbck_rdidx)
    );

    assign wb_hs       = wbck_valid & wbck_ready;
    assign cnt_zero    = (cnt_reg == '0);
    // A retiring write-back frees its credit in the same cycle.
    assign issue_ready = (cnt_reg != CNT_W'(OUTS_MAX)) | wb_hs;
    assign issue_hs    = issue_valid & issue_ready;
    assign busy        = ~cnt_zero | wbck_valid;

    // Outstanding-instruction counter; never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (issue_hs && !wb_hs) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end else if (wb_hs && !issue_hs && !cnt_zero) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

`ifdef EAI_WB_STALL_WDOG_EN
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    logic [STALL_W-1:0] stall_cnt_reg;
    logic               stall_err_reg;
    logic               stalled;

    assign stalled   = wbck_valid & ~wbck_ready;
    assign stall_err = stall_err_reg;

    // Saturating stall counter and sticky error; an unmatched write-back
    // (no outstanding credit) is reported through the same flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
            stall_err_reg <= 1'b0;
        end else begin
            if (!wbck_valid || wb_hs) begin
                stall_cnt_reg <= '0;
            end else if (stall_cnt_reg != STALL_W'(STALL_LIMIT)) begin
                stall_cnt_reg <= stall_cnt_reg + STALL_W'(1);
            end
            if ((stalled && stall_cnt_reg >= STALL_W'(STALL_LIMIT - 1)) ||
                (wb_hs && cnt_zero)) begin
                stall_err_reg <= 1'b1;
            end
        end
    end
`else
    assign stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_eai_wb_drain.sv
// Directed self-checking bench for eai_wb_drain. Watchdog expectations
// follow whether EAI_WB_STALL_WDOG_EN is defined for the build.
`timescale 1ns/1ps

module tb_eai_wb_drain;

    localparam int DW      = 32;
    localparam int RFIDX_W = 5;
`ifdef EAI_WB_STALL_WDOG_EN
    localparam logic WDOG = 1'b1;
`else
    localparam logic WDOG = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  issue_valid;
    logic                  issue_ready;
    logic                  buf_valid;
    logic                  buf_ready;
    logic [DW+RFIDX_W-1:0] buf_data;
    logic                  wbck_valid;
    logic                  wbck_ready;
    logic [DW-1:0]         wbck_wdat;
    logic [RFIDX_W-1:0]    wbck_rdidx;
    logic                  busy;
    logic                  stall_err;

    int checks = 0;
    int errors = 0;

    eai_wb_drain #(
        .DW          (DW),
        .RFIDX_W     (RFIDX_W),
        .OUTS_MAX    (2),
        .STALL_LIMIT (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .buf_valid   (buf_valid),
        .buf_ready   (buf_ready),
        .buf_data    (buf_data),
        .wbck_valid  (wbck_valid),
        .wbck_ready  (wbck_ready),
        .wbck_wdat   (wbck_wdat),
        .wbck_rdidx  (wbck_rdidx),
        .busy        (busy),
        .stall_err   (stall_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        issue_valid = 1'b0;
        buf_valid   = 1'b0;
        buf_data    = '0;
        wbck_ready  = 1'b0;
        rst_n       = 1'b0;
        #2;
        rst_n       = 1'b1;
    endtask

    initial begin
        issue_valid = 1'b0;
        buf_valid   = 1'b0;
        buf_data    = '0;
        wbck_ready  = 1'b0;
        rst_n       = 1'b0;

        // Reset values
        #3;
        check("rst_wbck_valid", wbck_valid, 0);
        check("rst_wbck_wdat", wbck_wdat, 0);
        check("rst_wbck_rdidx", wbck_rdidx, 0);
        check("rst_buf_ready", buf_ready, 1);
        check("rst_issue_ready", issue_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_stall_err", stall_err, 0);
        tick();
        rst_n = 1'b1;

        // Single entry, one-cycle latency
        tick();
        buf_valid  = 1'b1;
        buf_data   = {5'd3, 32'hDEADBEEF};
        wbck_ready = 1'b1;
        tick();
        buf_valid = 1'b0;
        check("single_valid", wbck_valid, 1);
        check("single_rdidx", wbck_rdidx, 3);
        check("single_wdat", wbck_wdat, 32'hDEADBEEF);
        check("single_busy", busy, 1);
        tick();
        check("single_done_valid", wbck_valid, 0);
        check("single_done_busy", busy, 0);
        check("underflow_flag", stall_err, WDOG);

        // Back-to-back, full throughput
        do_reset();
        tick();
        wbck_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            buf_valid = 1'b1;
            buf_data  = {5'(i + 1), 32'h1000 + 32'(i)};
            #1;
            check("b2b_buf_ready", buf_ready, 1);
            tick();
            check("b2b_valid", wbck_valid, 1);
            check("b2b_wdat", wbck_wdat, 32'h1000 + 32'(i));
            check("b2b_rdidx", wbck_rdidx, 5'(i + 1));
        end
        buf_valid = 1'b0;
        tick();
        check("b2b_drained", wbck_valid, 0);

        // Backpressure with two entries pending
        do_reset();
        tick();
        buf_valid = 1'b1;
        buf_data  = {5'd7, 32'hAAAA0001};
        tick();
        buf_data  = {5'd9, 32'hBBBB0002};
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", wbck_valid, 1);
            check("bp_hold_wdat", wbck_wdat, 32'hAAAA0001);
            check("bp_hold_rdidx", wbck_rdidx, 7);
            check("bp_buf_ready", buf_ready, 0);
            tick();
        end
        wbck_ready = 1'b1;
        #1;
        check("bp_release_ready", buf_ready, 1);
        check("bp_first_wdat", wbck_wdat, 32'hAAAA0001);
        tick();
        buf_valid = 1'b0;
        check("bp_second_valid", wbck_valid, 1);
        check("bp_second_wdat", wbck_wdat, 32'hBBBB0002);
        check("bp_second_rdidx", wbck_rdidx, 9);
        tick();
        check("bp_drained", wbck_valid, 0);

        // Credit accounting
        do_reset();
        tick();
        issue_valid = 1'b1;
        tick();
        tick();
        issue_valid = 1'b0;
        #1;
        check("cr_full_ready", issue_ready, 0);
        check("cr_full_cnt", dut.cnt_reg, 2);
        check("cr_full_busy", busy, 1);
        buf_valid = 1'b1;
        buf_data  = {5'd1, 32'hC0C0C0C0};
        tick();
        buf_valid = 1'b0;
        check("cr_hold_issue_ready", issue_ready, 0);
        wbck_ready  = 1'b1;
        issue_valid = 1'b1;
        #1;
        check("cr_swap_issue_ready", issue_ready, 1);
        tick();
        issue_valid = 1'b0;
        wbck_ready  = 1'b0;
        #1;
        check("cr_swap_cnt", dut.cnt_reg, 2);
        check("cr_after_issue_ready", issue_ready, 0);
        check("cr_after_valid", wbck_valid, 0);
        check("cr_stall_err", stall_err, 0);

        // Watchdog with STALL_LIMIT=8
        do_reset();
        tick();
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        buf_valid   = 1'b1;
        buf_data    = {5'd4, 32'h5A5A5A5A};
        tick();
        buf_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("wd_before_limit", stall_err, 0);
        tick();
        check("wd_at_limit", stall_err, WDOG);
        wbck_ready = 1'b1;
        tick();
        wbck_ready = 1'b0;
        check("wd_sticky_1", stall_err, WDOG);
        tick();
        check("wd_sticky_2", stall_err, WDOG);

        // Reset asserted while holding an entry
        do_reset();
        tick();
        issue_valid = 1'b1;
        buf_valid   = 1'b1;
        buf_data    = {5'd12, 32'h12345678};
        tick();
        issue_valid = 1'b0;
        buf_valid   = 1'b0;
        check("hr_holding", wbck_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("hr_valid", wbck_valid, 0);
        check("hr_cnt", dut.cnt_reg, 0);
        check("hr_busy", busy, 0);
        check("hr_wdat", wbck_wdat, 0);
        check("hr_issue_ready", issue_ready, 1);
        tick();
        rst_n      = 1'b1;
        wbck_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hr_no_writeback", wbck_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eai_wb_drain.md
EAI_WB_DRAIN -- requirements
Module: eai_wb_drain

Interface
REQ-001 SHALL have parameter DW, default 32, meaning write-back data width.
REQ-002 SHALL have parameter RFIDX_W, default 5, meaning register-file index width.
REQ-003 SHALL have parameter OUTS_MAX, default 2, meaning maximum outstanding EAI instructions (equals the ping-pong depth).
REQ-004 SHALL have parameter STALL_LIMIT, default 255, meaning watchdog threshold in cycles.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 issue_valid  input  1  EAI instruction dispatched by the core.
REQ-008 issue_ready  output  1  credit available to accept a dispatch.
REQ-009 buf_valid  input  1  buffer read side holds an entry.
REQ-010 buf_ready  output  1  entry consumed this cycle.
REQ-011 buf_data  input  DW+RFIDX_W  entry payload: {rdidx, wdat}, rdidx in the MSBs.
REQ-012 wbck_valid  output  1  register-file write request.
REQ-013 wbck_ready  input  1  register-file write accepted.
REQ-014 wbck_wdat  output  DW  write data.
REQ-015 wbck_rdidx  output  RFIDX_W  destination register.
REQ-016 busy  output  1  outstanding count nonzero or output register occupied.
REQ-017 stall_err  output  1  sticky watchdog flag; tied to 0 when the watchdog is compiled out.

Function
REQ-018 One output register (ovld, odata, oidx); states EMPTY (ovld=0) and HOLD (ovld=1).
REQ-019 buf_ready = ~ovld | wbck_ready; full throughput, one entry per cycle.
REQ-020 Buffer handshake (buf_valid & buf_ready) loads odata/oidx and sets ovld the next cycle; latency exactly 1 cycle.
REQ-021 wbck_valid = ovld; wbck_wdat/wbck_rdidx = odata/oidx; held stable while wbck_valid & ~wbck_ready.
REQ-022 Transitions: EMPTY->HOLD on buffer handshake; HOLD->EMPTY on wbck handshake with no buffer handshake; HOLD->HOLD on both handshakes in the same cycle, with the new entry loaded.
REQ-023 Outstanding counter, width clog2(OUTS_MAX+1): +1 on issue_valid & issue_ready; -1 on wbck handshake; unchanged when both occur.
REQ-024 issue_ready = (cnt != OUTS_MAX) | (wbck_valid & wbck_ready).
REQ-025 A wbck handshake with cnt==0 SHALL NOT decrement (no underflow) and SHALL set stall_err when the watchdog is enabled.
REQ-026 busy = (cnt != 0) | ovld.

Reset
REQ-027 Reset SHALL clear ovld, odata, oidx, cnt, the stall counter and stall_err, asynchronously.
REQ-028 Output values in reset: wbck_valid=0, wbck_wdat=0, wbck_rdidx=0, buf_ready=1, issue_ready=1, busy=0, stall_err=0.
REQ-029 Reset asserted mid-HOLD SHALL drop the held entry with no write-back.

Configuration
REQ-030 Macro EAI_WB_STALL_WDOG_EN defined: stall counter increments each cycle wbck_valid & ~wbck_ready, clears on wbck handshake or when ovld=0, saturates at STALL_LIMIT; reaching STALL_LIMIT sets stall_err, which stays set until reset.
REQ-031 Macro EAI_WB_STALL_WDOG_EN undefined: no stall counter, stall_err tied 0, underflow is not flagged; all other behaviour unchanged.

Structure
REQ-032 Shared package eai_wb_pkg SHALL hold the payload field offsets, the EMPTY/HOLD encoding and the default OUTS_MAX and STALL_LIMIT values.
REQ-033 The output register SHALL be the sub-module eai_wb_outreg; counter and watchdog logic stay in the top module.

Verification
REQ-034 Single entry: buf_data={5'd3,32'hDEADBEEF}, wbck_ready=1 -> wbck_valid 1 cycle later, rdidx=3, wdat=DEADBEEF, busy drops the following cycle.
REQ-035 Back-to-back: 4 entries on consecutive cycles with wbck_ready=1 -> 4 write-backs on consecutive cycles, buf_ready stays 1.
REQ-036 Backpressure: wbck_ready=0 for 5 cycles with 2 entries pending -> the first entry is held stable, buf_ready=0, then both entries write back in order.
REQ-037 Credit: 2 dispatches with no write-back -> issue_ready=0; a write-back and a third dispatch in the same cycle -> the dispatch is accepted and cnt stays 2.
REQ-038 Watchdog (macro defined, STALL_LIMIT=8): wbck_ready=0 for 8 cycles -> stall_err=1 and stays 1 after wbck_ready returns; with the macro undefined, stall_err stays 0.
REQ-039 Reset during HOLD -> wbck_valid=0 and cnt=0 immediately, and no write-back follows.
